dic_search_ctrl: RTL and testbench
==================================

DIC_SEARCH_CTRL -- requirements
Module: dic_search_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, is the maximum number of cycles RamRead waits for RamAck (range 1..255).
REQ-002 Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Rst_n  input  1  synchronous reset, active-low; sampled on rising edge of Clk.
REQ-004 Start  input  1  single-cycle request to search the dictionary for the current String.
REQ-005 RamAck  input  1  RAM read data valid on iRAMBuffer this cycle.
REQ-006 DicPointerEqualsInsertPointer, StringRAMSizeEqualsStringSize, DicPointerEqualsJumpAddress, StringRAMEqualsString  input  1 each  datapath condition flags.
REQ-007 LoadDicPointer, DicPointerIncrement, LoadJumpAddress, SetJumpAddress, StringRAMLoad, StringRAMZero, Found, NotFound  output  1 each  datapath control strobes.
REQ-008 RamRead  output  1  read request to dictionary RAM at ramDicPointer.
REQ-009 Busy  output  1  high in every state except IDLE.
REQ-010 Done  output  1  one-cycle pulse at search end.
REQ-011 Error  output  1  one-cycle pulse, coincident with Done, on RAM ack timeout.

Function
REQ-012 The controller SHALL be a Moore FSM; all outputs decode from current state only, and every strobe is low in states not listed.
REQ-013 IDLE: no strobes; Start -> INIT; otherwise stay.
REQ-014 INIT: LoadDicPointer=1 -> CHECK.
REQ-015 CHECK: StringRAMZero=1; DicPointerEqualsInsertPointer -> MISS, else -> REQ.
REQ-016 REQ: RamRead=1; RamAck -> HDR; timeout -> ERR; else stay.
REQ-017 HDR: StringRAMLoad=1, DicPointerIncrement=1 -> SIZE.
REQ-018 SIZE: SetJumpAddress=1; StringRAMSizeEqualsStringSize -> DCHK, else -> JUMP.
REQ-019 JUMP: LoadJumpAddress=1 -> CHECK.
REQ-020 DCHK: DicPointerEqualsJumpAddress -> CMP, else -> DREQ.
REQ-021 DREQ: RamRead=1; RamAck -> DATA; timeout -> ERR; else stay.
REQ-022 DATA: StringRAMLoad=1, DicPointerIncrement=1 -> DCHK.
REQ-023 CMP: StringRAMEqualsString -> HIT, else -> CHECK.
REQ-024 HIT: Found=1, Done=1 -> IDLE. MISS: NotFound=1, Done=1 -> IDLE. ERR: NotFound=1, Done=1, Error=1 -> IDLE.
REQ-025 Wait counter (8 bit) SHALL clear on entry to REQ/DREQ, increment each cycle there without RamAck; timeout occurs when counter equals ACK_TIMEOUT-1 with RamAck low, i.e. exactly ACK_TIMEOUT wait cycles.
REQ-026 RamAck in the timeout cycle SHALL win (normal transition, no ERR).
REQ-027 RamAck outside REQ/DREQ SHALL be ignored; Start while Busy SHALL be ignored.
REQ-028 Minimum latency Start-to-Done for an immediate miss (pointer equals insert pointer): Start at edge N, INIT N+1, CHECK N+2, MISS N+3, Done high during cycle N+3.
REQ-029 Condition inputs SHALL be sampled only in the state that tests them.

Reset
REQ-030 Rst_n low at a rising edge SHALL force IDLE, clear wait counter, and drive all outputs 0 from that edge, including mid-search; RAM request is dropped without waiting for RamAck.
REQ-031 After Rst_n returns high the controller SHALL accept Start on the first following edge.

Verification
REQ-032 Empty dictionary: DicPointerEqualsInsertPointer=1, pulse Start -> INIT, CHECK, MISS; NotFound=1 and Done=1 exactly 3 cycles after Start; Found never high.
REQ-033 Size mismatch then hit: first header StringRAMSizeEqualsStringSize=0 -> SetJumpAddress, LoadJumpAddress, back to CHECK; second entry size match, two data words acked, then DicPointerEqualsJumpAddress=1, StringRAMEqualsString=1 -> Found=1, Done=1; StringRAMLoad pulsed 4 times total.
REQ-034 Ack timeout: ACK_TIMEOUT=15, RamAck held low in REQ -> RamRead high exactly 15 cycles, then Error=1, NotFound=1, Done=1 for one cycle, Busy low next cycle.
REQ-035 Ack on last cycle: RamAck first high on 15th REQ cycle -> HDR entered, Error stays 0.
REQ-036 Reset mid-operation: Rst_n low during DREQ with RamRead=1 -> next edge all outputs 0, Busy=0; Start after release completes a normal search; Start pulsed while Busy is ignored (no restart, single Done).

Source files
------------

// File: rtl/dic_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dic_search_ctrl
//  Purpose  : Moore FSM that sequences a dictionary search. It walks entries
//             (header, size, data words), compares against the current
//             string, and reports hit / miss / RAM-ack timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module dic_search_ctrl #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Start,
  input  logic RamAck,
  input  logic DicPointerEqualsInsertPointer,
  input  logic StringRAMSizeEqualsStringSize,
  input  logic DicPointerEqualsJumpAddress,
  input  logic StringRAMEqualsString,
  output logic LoadDicPointer,
  output logic DicPointerIncrement,
  output logic LoadJumpAddress,
  output logic SetJumpAddress,
  output logic StringRAMLoad,
  output logic StringRAMZero,
  output logic Found,
  output logic NotFound,
  output logic RamRead,
  output logic Busy,
  output logic Done,
  output logic Error
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_INIT  = 4'd1,
    S_CHECK = 4'd2,
    S_REQ   = 4'd3,
    S_HDR   = 4'd4,
    S_SIZE  = 4'd5,
    S_JUMP  = 4'd6,
    S_DCHK  = 4'd7,
    S_DREQ  = 4'd8,
    S_DATA  = 4'd9,
    S_CMP   = 4'd10,
    S_HIT   = 4'd11,
    S_MISS  = 4'd12,
    S_ERR   = 4'd13
  } state_t;

  // Last wait-count value before a missing ack becomes a timeout.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic        ack_timeout;
  logic [11:0] ctrl;

  // Output bit order: LoadDicPointer, DicPointerIncrement, LoadJumpAddress,
  // SetJumpAddress, StringRAMLoad, StringRAMZero, Found, NotFound, RamRead,
  // Busy, Done, Error.
  function automatic logic [11:0] decode(input state_t s);
    logic [11:0] d;
    d = 12'b0;
    case (s)
      S_INIT:  d[11] = 1'b1;
      S_CHECK: d[6]  = 1'b1;
      S_REQ:   d[3]  = 1'b1;
      S_HDR:   begin d[7] = 1'b1; d[10] = 1'b1; end
      S_SIZE:  d[8]  = 1'b1;
      S_JUMP:  d[9]  = 1'b1;
      S_DREQ:  d[3]  = 1'b1;
      S_DATA:  begin d[7] = 1'b1; d[10] = 1'b1; end
      S_HIT:   begin d[5] = 1'b1; d[1] = 1'b1; end
      S_MISS:  begin d[4] = 1'b1; d[1] = 1'b1; end
      S_ERR:   begin d[4] = 1'b1; d[1] = 1'b1; d[0] = 1'b1; end
      default: d = 12'b0;
    endcase
    if (s != S_IDLE) d[2] = 1'b1;
    return d;
  endfunction

  // A late ack in the final wait cycle still counts as a normal ack.
  assign ack_timeout = (wait_cnt == TIMEOUT_LAST) && !RamAck;

  // Next-state selection; each condition flag is looked at only in its state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_INIT;
      S_INIT:  state_nxt = S_CHECK;
      S_CHECK: state_nxt = DicPointerEqualsInsertPointer ? S_MISS : S_REQ;
      S_REQ:   begin
        if (RamAck)           state_nxt = S_HDR;
        else if (ack_timeout) state_nxt = S_ERR;
      end
      S_HDR:   state_nxt = S_SIZE;
      S_SIZE:  state_nxt = StringRAMSizeEqualsStringSize ? S_DCHK : S_JUMP;
      S_JUMP:  state_nxt = S_CHECK;
      S_DCHK:  state_nxt = DicPointerEqualsJumpAddress ? S_CMP : S_DREQ;
      S_DREQ:  begin
        if (RamAck)           state_nxt = S_DATA;
        else if (ack_timeout) state_nxt = S_ERR;
      end
      S_DATA:  state_nxt = S_DCHK;
      S_CMP:   state_nxt = StringRAMEqualsString ? S_HIT : S_CHECK;
      S_HIT,
      S_MISS,
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, wait counter and registered Moore outputs (decoded from next state).
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      ctrl     <= 12'b0;
    end else begin
      state <= state_nxt;
      ctrl  <= decode(state_nxt);
      // Staying in a wait state means no ack arrived; entering one restarts.
      if ((state_nxt == S_REQ || state_nxt == S_DREQ) && state == state_nxt)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
    end
  end

  assign {LoadDicPointer, DicPointerIncrement, LoadJumpAddress, SetJumpAddress,
          StringRAMLoad, StringRAMZero, Found, NotFound, RamRead,
          Busy, Done, Error} = ctrl;

endmodule
`default_nettype wire

// File: tb/tb_dic_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dic_search_ctrl
//  Purpose  : Scenario bench for dic_search_ctrl with a result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dic_search_ctrl;
  localparam int ACK_TIMEOUT = 15;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic Start = 1'b0;
  logic RamAck = 1'b0;
  logic dpeip = 1'b0;
  logic size_eq = 1'b0;
  logic dpeja = 1'b0;
  logic str_eq = 1'b0;
  logic LoadDicPointer, DicPointerIncrement, LoadJumpAddress, SetJumpAddress;
  logic StringRAMLoad, StringRAMZero, Found, NotFound, RamRead, Busy, Done, Error;
  logic [11:0] outs;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic found; logic not_found; logic error;} exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 Clk = ~Clk;

  dic_search_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .RamAck(RamAck),
    .DicPointerEqualsInsertPointer(dpeip),
    .StringRAMSizeEqualsStringSize(size_eq),
    .DicPointerEqualsJumpAddress(dpeja),
    .StringRAMEqualsString(str_eq),
    .LoadDicPointer(LoadDicPointer), .DicPointerIncrement(DicPointerIncrement),
    .LoadJumpAddress(LoadJumpAddress), .SetJumpAddress(SetJumpAddress),
    .StringRAMLoad(StringRAMLoad), .StringRAMZero(StringRAMZero),
    .Found(Found), .NotFound(NotFound), .RamRead(RamRead),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  assign outs = {LoadDicPointer, DicPointerIncrement, LoadJumpAddress, SetJumpAddress,
                 StringRAMLoad, StringRAMZero, Found, NotFound, RamRead, Busy, Done, Error};

  // Advance one clock; outputs are read and inputs driven 1 ns after the edge.
  task step();
    @(posedge Clk);
    #1;
  endtask

  task test_reset();
    Rst_n = 1'b0; Start = 1'b1; RamAck = 1'b1;
    step(); step(); step();
    checks++;
    if (outs !== 12'b0) begin errors++; $display("FAIL reset_outs: got %b exp %b", outs, 12'b0); end
    Rst_n = 1'b1; Start = 1'b0; RamAck = 1'b0;
    step();
    checks++;
    if (outs !== 12'b0) begin errors++; $display("FAIL idle_outs: got %b exp %b", outs, 12'b0); end
  endtask

  task test_empty_dict();
    int lat; bit got; int nfound;
    lat = 0; got = 0; nfound = 0;
    dpeip = 1'b1; RamAck = 1'b1;
    Start = 1'b1; sb.push_back('{1'b0, 1'b1, 1'b0});
    step();
    Start = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      if (Found) nfound++;
      if (i == 1) begin
        checks++;
        if (LoadDicPointer !== 1'b1) begin errors++; $display("FAIL empty_init: LoadDicPointer got %b exp 1", LoadDicPointer); end
      end
      if (i == 2) begin
        checks++;
        if (StringRAMZero !== 1'b1) begin errors++; $display("FAIL empty_check: StringRAMZero got %b exp 1", StringRAMZero); end
      end
      if (Done) begin
        got = 1; lat = i;
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL empty_sb: queue empty at Done"); end
        else begin
          e = sb.pop_front(); checks++;
          if ({Found, NotFound, Error} !== e) begin errors++; $display("FAIL empty_result: got %b exp %b", {Found, NotFound, Error}, e); end
        end
      end else step();
    end
    checks++;
    if (!got) begin errors++; $display("FAIL empty_done: no Done within 10 cycles"); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL empty_latency: got %0d exp 3", lat); end
    checks++;
    if (nfound != 0) begin errors++; $display("FAIL empty_found: Found cycles got %0d exp 0", nfound); end
    step();
    checks++;
    if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL empty_after: Busy,Done got %b exp 00", {Busy, Done}); end
    dpeip = 1'b0; RamAck = 1'b0;
  endtask

  task test_size_miss_hit();
    int nload; int nsize; int njump; bit got;
    nload = 0; nsize = 0; njump = 0; got = 0;
    dpeip = 1'b0; str_eq = 1'b1; size_eq = 1'b0; dpeja = 1'b0;
    Start = 1'b1; sb.push_back('{1'b1, 1'b0, 1'b0});
    step();
    Start = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      RamAck = RamRead;
      if (SetJumpAddress) begin nsize++; size_eq = (nsize >= 2); end
      if (StringRAMLoad) nload++;
      if (LoadJumpAddress) njump++;
      dpeja = (nload >= 4);
      if (Done) begin
        got = 1;
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL hit_sb: queue empty at Done"); end
        else begin
          e = sb.pop_front(); checks++;
          if ({Found, NotFound, Error} !== e) begin errors++; $display("FAIL hit_result: got %b exp %b", {Found, NotFound, Error}, e); end
        end
      end else step();
    end
    checks++;
    if (!got) begin errors++; $display("FAIL hit_done: no Done within 200 cycles"); end
    checks++;
    if (nload != 4) begin errors++; $display("FAIL hit_loads: StringRAMLoad pulses got %0d exp 4", nload); end
    checks++;
    if (nsize != 2) begin errors++; $display("FAIL hit_sizes: SetJumpAddress pulses got %0d exp 2", nsize); end
    checks++;
    if (njump != 1) begin errors++; $display("FAIL hit_jumps: LoadJumpAddress pulses got %0d exp 1", njump); end
    RamAck = 1'b0;
    step();
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL hit_after: Busy got %b exp 0", Busy); end
    str_eq = 1'b0; size_eq = 1'b0; dpeja = 1'b0;
  endtask

  task test_timeout();
    int nread; bit got;
    nread = 0; got = 0;
    dpeip = 1'b0; RamAck = 1'b0;
    Start = 1'b1; sb.push_back('{1'b0, 1'b1, 1'b1});
    step();
    Start = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (RamRead) nread++;
      if (Done) begin
        got = 1;
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL tmo_sb: queue empty at Done"); end
        else begin
          e = sb.pop_front(); checks++;
          if ({Found, NotFound, Error} !== e) begin errors++; $display("FAIL tmo_result: got %b exp %b", {Found, NotFound, Error}, e); end
        end
      end else step();
    end
    checks++;
    if (!got) begin errors++; $display("FAIL tmo_done: no Done within 100 cycles"); end
    checks++;
    if (nread != ACK_TIMEOUT) begin errors++; $display("FAIL tmo_reads: RamRead cycles got %0d exp %0d", nread, ACK_TIMEOUT); end
    step();
    checks++;
    if ({Busy, Done, Error} !== 3'b000) begin errors++; $display("FAIL tmo_after: Busy,Done,Error got %b exp 000", {Busy, Done, Error}); end
  endtask

  task test_ack_last();
    int nread; int nerr; bit hdr_seen; bit got;
    nread = 0; nerr = 0; hdr_seen = 0; got = 0;
    dpeip = 1'b0; RamAck = 1'b0; size_eq = 1'b0;
    Start = 1'b1; sb.push_back('{1'b0, 1'b1, 1'b0});
    step();
    Start = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (RamRead) begin nread++; RamAck = (nread == ACK_TIMEOUT); end
      else RamAck = 1'b0;
      if (Error) nerr++;
      if (StringRAMLoad && !hdr_seen) begin
        hdr_seen = 1; checks++;
        if (nread != ACK_TIMEOUT) begin errors++; $display("FAIL last_reads: RamRead cycles got %0d exp %0d", nread, ACK_TIMEOUT); end
      end
      dpeip = hdr_seen;
      if (Done) begin
        got = 1;
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL last_sb: queue empty at Done"); end
        else begin
          e = sb.pop_front(); checks++;
          if ({Found, NotFound, Error} !== e) begin errors++; $display("FAIL last_result: got %b exp %b", {Found, NotFound, Error}, e); end
        end
      end else step();
    end
    checks++;
    if (!got) begin errors++; $display("FAIL last_done: no Done within 100 cycles"); end
    checks++;
    if (hdr_seen != 1'b1) begin errors++; $display("FAIL last_hdr: header state seen %b exp 1", hdr_seen); end
    checks++;
    if (nerr != 0) begin errors++; $display("FAIL last_error: Error cycles got %0d exp 0", nerr); end
    RamAck = 1'b0;
    step();
    dpeip = 1'b0;
  endtask

  task test_reset_mid();
    int nload; int ndreq; int ndone;
    nload = 0; ndreq = 0; ndone = 0;
    dpeip = 1'b0; size_eq = 1'b1; dpeja = 1'b0; str_eq = 1'b0; RamAck = 1'b0;
    Start = 1'b1; sb.push_back('{1'b1, 1'b0, 1'b0});
    step();
    Start = 1'b0;
    for (int i = 0; i < 50 && ndreq < 3; i++) begin
      if (StringRAMLoad) nload++;
      if (RamRead && nload == 1) ndreq++;
      RamAck = RamRead && (nload == 0);
      if (ndreq < 3) step();
    end
    checks++;
    if (RamRead !== 1'b1) begin errors++; $display("FAIL mid_dreq: RamRead got %b exp 1 before reset", RamRead); end
    Rst_n = 1'b0; RamAck = 1'b0;
    step();
    sb.delete();
    checks++;
    if (outs !== 12'b0) begin errors++; $display("FAIL mid_reset: got %b exp %b", outs, 12'b0); end
    Rst_n = 1'b1; Start = 1'b1; dpeip = 1'b1;
    sb.push_back('{1'b0, 1'b1, 1'b0});
    step();
    checks++;
    if ({LoadDicPointer, Busy} !== 2'b11) begin errors++; $display("FAIL mid_restart: LoadDicPointer,Busy got %b exp 11", {LoadDicPointer, Busy}); end
    for (int i = 0; i < 12; i++) begin
      Start = Busy;
      if (Done) begin
        ndone++;
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL mid_sb: queue empty at Done"); end
        else begin
          e = sb.pop_front(); checks++;
          if ({Found, NotFound, Error} !== e) begin errors++; $display("FAIL mid_result: got %b exp %b", {Found, NotFound, Error}, e); end
        end
      end
      step();
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL mid_done_count: got %0d exp 1", ndone); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL mid_idle: Busy got %b exp 0", Busy); end
    Start = 1'b0; dpeip = 1'b0; size_eq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_empty_dict();
    test_size_miss_hit();
    test_timeout();
    test_ack_last();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
